// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package pipe_pkg;

    // Register-address width used across the pipeline control logic.
    localparam int RA_W = 5;

    // Sequencer states: normal flow, waiting on data memory, waiting on instruction memory.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2
    } ctrl_state_t;

    // Execute-stage operand source selects.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // The single hazard response chosen in a given cycle, in priority order.
    typedef enum logic [2:0] {
        ACT_NONE    = 3'd0,  // pipeline flows freely
        ACT_DHOLD   = 3'd1,  // data memory busy: freeze F..M, bubble into W
        ACT_BRANCH  = 3'd2,  // taken branch: squash D and E
        ACT_LOADUSE = 3'd3,  // load-use: hold F/D, bubble into E
        ACT_IMISS   = 3'd4,  // fetch not ready: hold F, bubble into D
        ACT_IHOLD   = 3'd5   // still waiting on fetch
    } hz_action_t;

    // Pipeline-register control pins driven by the sequencer.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctl_t;

endpackage

// File: rtl/fwd_unit.sv
// Execute-stage forwarding selection. Purely combinational; the memory stage
// result is newer than the writeback result, so it takes priority.
module fwd_unit #(
    parameter int RA_W = pipe_pkg::RA_W
) (
    input  logic [RA_W-1:0] Rs1E,
    input  logic [RA_W-1:0] Rs2E,
    input  logic [RA_W-1:0] RdM,
    input  logic [RA_W-1:0] RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE
);
    import pipe_pkg::*;

    // x0 is hard-wired to zero, so a write to it never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] rs,
        input logic [RA_W-1:0] rd_m,
        input logic [RA_W-1:0] rd_w,
        input logic            we_m,
        input logic            we_w
    );
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard and stall sequencer for the 5-stage pipeline. Picks one hazard
// response per cycle, drives the stage-register stall/flush pins, sequences
// multi-cycle memory waits and keeps stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int RA_W  = pipe_pkg::RA_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  Rs1D,
    input  logic [RA_W-1:0]  Rs2D,
    input  logic [RA_W-1:0]  Rs1E,
    input  logic [RA_W-1:0]  Rs2E,
    input  logic [RA_W-1:0]  RdE,
    input  logic [RA_W-1:0]  RdM,
    input  logic [RA_W-1:0]  RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import pipe_pkg::*;

    ctrl_state_t state;
    ctrl_state_t next_state;
    hz_action_t  action;
    hz_ctl_t     ctl;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        lw_stall;
    logic        dstall;
    logic        istall;
    logic        data_hold;
    logic        branch_flush;

    fwd_unit #(
        .RA_W(RA_W)
    ) u_fwd (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_a),
        .ForwardBE (fwd_b)
    );

    assign lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign dstall   = MemReqM && !dmem_ready;
    assign istall   = !imem_ready;

    // Once in DWAIT the memory stage is frozen, so release depends only on dmem_ready.
    assign data_hold = (state == DWAIT) ? !dmem_ready : dstall;

    // Pick the winning hazard response; a released wait falls through to the normal rules.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        action = ACT_NONE;
        if ((state == IWAIT) && !dstall && !PCSrcE && istall) begin
            action = ACT_IHOLD;
        end else if (data_hold) begin
            action = ACT_DHOLD;
        end else if (PCSrcE) begin
            action = ACT_BRANCH;
        end else if (lw_stall) begin
            action = ACT_LOADUSE;
        end else if (istall) begin
            action = ACT_IMISS;
        end
    end

    // State register; reset drops any outstanding wait immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= next_state;
        end
    end

    // Next-state decode from the chosen response.
    always_comb begin
        next_state = RUN;
        unique case (action)
            ACT_DHOLD:  next_state = DWAIT;
            ACT_IMISS,
            ACT_IHOLD:  next_state = IWAIT;
            default:    next_state = RUN;
        endcase
    end

    // Stage-register control pins; reset forces bubbles everywhere and no stalls.
    always_comb begin
        ctl = '0;
        if (rst) begin
            ctl.flush_d = 1'b1;
            ctl.flush_e = 1'b1;
            ctl.flush_w = 1'b1;
        end else begin
            unique case (action)
                ACT_DHOLD: begin
                    ctl.stall_f = 1'b1;
                    ctl.stall_d = 1'b1;
                    ctl.stall_e = 1'b1;
                    ctl.stall_m = 1'b1;
                    ctl.flush_w = 1'b1;
                end
                ACT_BRANCH: begin
                    ctl.flush_d = 1'b1;
                    ctl.flush_e = 1'b1;
                end
                ACT_LOADUSE: begin
                    ctl.stall_f = 1'b1;
                    ctl.stall_d = 1'b1;
                    ctl.flush_e = 1'b1;
                end
                ACT_IMISS,
                ACT_IHOLD: begin
                    ctl.stall_f = 1'b1;
                    ctl.flush_d = 1'b1;
                end
                default: ctl = '0;
            endcase
        end
    end

    assign branch_flush = !rst && (action == ACT_BRANCH);

    assign StallF    = ctl.stall_f;
    assign StallD    = ctl.stall_d;
    assign StallE    = ctl.stall_e;
    assign StallM    = ctl.stall_m;
    assign FlushD    = ctl.flush_d;
    assign FlushE    = ctl.flush_e;
    assign FlushW    = ctl.flush_w;
    assign ForwardAE = rst ? FWD_RF : fwd_a;
    assign ForwardBE = rst ? FWD_RF : fwd_b;

    // Performance counters: fetch-stall cycles and branch-caused execute flushes, wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctl.stall_f) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_flush) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and stall sequencer for the 5-stage RISC-V pipeline. Drives the enable/clear pins of the F/D, D/E, E/M and M/W pipeline registers and the execute-stage forwarding muxes. Sequences multi-cycle instruction- and data-memory waits through a small FSM. Keeps stall and flush performance counters.

Parameters:
RA_W, 5, register-address width
CNT_W, 32, performance-counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
Rs1D, Rs2D  in  RA_W  source regs in decode
Rs1E, Rs2E, RdE  in  RA_W  regs in execute
RdM, RdW  in  RA_W  dest regs in memory / writeback
RegWriteM, RegWriteW  in  1  writeback enables
LoadE  in  1  execute-stage instr is a load
PCSrcE  in  1  taken branch/jump resolved in execute
MemReqM  in  1  memory-stage instr accesses dmem
dmem_ready  in  1  dmem completes access this cycle
imem_ready  in  1  imem returns a valid instruction this cycle
StallF, StallD, StallE, StallM  out  1  hold stage register (enable = ~Stall)
FlushD, FlushE, FlushW  out  1  clear stage register (insert bubble)
ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- FSM states: RUN, DWAIT, IWAIT. State is registered; all hazard outputs are combinational from the state plus the inputs.
- Reset: state=RUN, counters=0. While rst=1: FlushD=FlushE=FlushW=1, all Stall*=0, Forward*=00.
- Forwarding in every state. ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E. Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E. Else 00. ForwardBE is the same using Rs2E. M has priority over W.
- lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- dstall = MemReqM && !dmem_ready. istall = !imem_ready.
- RUN:
  - dstall: StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0. PCSrcE is ignored this cycle because the branch stays held in E. Next state DWAIT.
  - else PCSrcE: FlushD=FlushE=1, StallF=StallD=0. lwStall and istall are suppressed. Stay in RUN.
  - else lwStall: StallF=StallD=1, FlushE=1. Stay in RUN.
  - else istall: StallF=1, FlushD=1. Next state IWAIT.
  - else all 0.
- DWAIT: same outputs as the RUN-dstall case while !dmem_ready. On dmem_ready, evaluate exactly as RUN in that same cycle (branch, lwStall, istall) and move to RUN, or to IWAIT if istall wins.
- IWAIT: StallF=1, FlushD=1. Later stages advance.
  - dstall has priority: apply the DWAIT outputs and go to DWAIT.
  - PCSrcE: FlushD=FlushE=1, StallF=0 (PC redirects), go to RUN. The outstanding fetch is discarded by the fetch unit.
  - imem_ready && !PCSrcE: go to RUN and apply the RUN lwStall rules in the same cycle.
- Simultaneous load-use and taken branch: the flush wins and no stall is raised.
- Simultaneous dmem wait and taken branch: the wait wins; the branch is taken after release.
- stall_cnt increments in any cycle with StallF=1. flush_cnt increments in any cycle with FlushE=1 caused by PCSrcE. Both wrap modulo 2^CNT_W and are not incremented during rst.
- Reset asserted mid-wait: returns immediately to RUN with the reset outputs.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum ctrl_state_t {RUN, DWAIT, IWAIT};
  - forwarding-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - RA_W.
- One sub-module, fwd_unit (purely combinational Forward*E logic), instantiated once. FSM and counters stay in the top.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Set RdM=0 -> ForwardAE=01. Rs2E=0 with RdW=0, RegWriteW=1 -> ForwardBE=00.
- Load-use: LoadE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for exactly 1 cycle, stall_cnt +1. RdE=0 -> no stall.
- Branch vs load-use: PCSrcE=1, LoadE=1, RdE=Rs1D=4 -> FlushD=FlushE=1, StallD=0, flush_cnt +1.
- Dmem wait: MemReqM=1, dmem_ready low for 3 cycles, PCSrcE=1 throughout -> StallF..StallM=1 and FlushW=1 for 3 cycles, no flush. Cycle 4 (ready) -> FlushD=FlushE=1. stall_cnt +3.
- Imem wait: imem_ready low for 2 cycles -> StallF=FlushD=1 for both cycles while StallE=0. Raise MemReqM with dmem_ready=0 in cycle 2 -> DWAIT outputs.
- Reset mid-DWAIT: assert rst asynchronously -> outputs go to reset values immediately, state=RUN, counters=0.
